// File: rtl/xm23_fetch_unit.sv
// XM23 instruction fetch stage: owns the PC, issues one-cycle word reads and presents each
// fetched instruction on a valid/ready handshake, gated by run/step, sleep and breakpoint.
module xm23_fetch_unit #(
  parameter logic [15:0] ResetPc    = 16'h0000,
  parameter logic [15:0] PcInc      = 16'd2,
  parameter int unsigned TimeoutCyc = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic        step_i,
  input  logic        sleep_i,
  input  logic [15:0] bkpnt_i,
  input  logic        bkpnt_en_i,
  input  logic        resume_i,
  input  logic        pc_load_i,
  input  logic [15:0] pc_load_val_i,
  output logic [15:0] mem_addr_o,
  output logic        mem_rd_o,
  input  logic        mem_ack_i,
  input  logic [15:0] mem_rdata_i,
  output logic [15:0] instr_o,
  output logic [15:0] instr_pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [15:0] pc_o,
  output logic        halted_o,
  output logic        fault_o
);

  localparam int unsigned CntW = (TimeoutCyc > 2) ? $clog2(TimeoutCyc) : 1;
  localparam logic [CntW-1:0] TmoLast = CntW'(TimeoutCyc - 1);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StHalt, StFault} state_e;

  state_e            state_q;
  logic [15:0]       pc_q;
  logic [15:0]       mem_addr_q;
  logic              mem_rd_q;
  logic [15:0]       instr_q;
  logic [15:0]       instr_pc_q;
  logic              instr_valid_q;
  logic              halted_q;
  logic              fault_q;
  logic              skip_q;
  logic              squash_q;
  logic              step_prev_q;
  logic              step_pend_q;
  logic [CntW-1:0]   tmo_q;

  logic step_edge;
  logic fetch_ok;
  logic bkpnt_hit;
  logic tmo_hit;

  assign step_edge = step_i & ~step_prev_q;
  assign fetch_ok  = ~sleep_i & (run_i | step_pend_q);
  assign bkpnt_hit = bkpnt_en_i & (pc_q == bkpnt_i) & ~skip_q;
  assign tmo_hit   = (tmo_q == TmoLast);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      pc_q          <= ResetPc;
      mem_addr_q    <= '0;
      mem_rd_q      <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
      skip_q        <= 1'b0;
      squash_q      <= 1'b0;
      step_prev_q   <= 1'b0;
      step_pend_q   <= 1'b0;
      tmo_q         <= '0;
    end else begin
      step_prev_q <= step_i;
      if (step_edge) step_pend_q <= 1'b1;

      if (pc_load_i) begin
        pc_q <= pc_load_val_i;
        unique case (state_q)
          StReq: begin
            mem_rd_q <= 1'b0;
            squash_q <= 1'b1;
            tmo_q    <= '0;
            state_q  <= StWait;
          end
          StWait: begin
            // The outstanding ack must still arrive (or time out) before we move on.
            if (mem_ack_i) begin
              squash_q <= 1'b0;
              state_q  <= StIdle;
            end else if (tmo_hit) begin
              squash_q <= 1'b0;
              fault_q  <= 1'b1;
              state_q  <= StFault;
            end else begin
              squash_q <= 1'b1;
              tmo_q    <= tmo_q + 1'b1;
            end
          end
          StHold: begin
            instr_valid_q <= 1'b0;
            state_q       <= StIdle;
          end
          default: begin
            halted_q <= 1'b0;
            skip_q   <= 1'b0;
            fault_q  <= 1'b0;
            state_q  <= StIdle;
          end
        endcase
      end else begin
        unique case (state_q)
          StIdle: begin
            if (fetch_ok) begin
              if (bkpnt_hit) begin
                halted_q <= 1'b1;
                state_q  <= StHalt;
              end else if (pc_q[0]) begin
                fault_q <= 1'b1;
                state_q <= StFault;
              end else begin
                mem_rd_q    <= 1'b1;
                mem_addr_q  <= pc_q;
                skip_q      <= 1'b0;
                step_pend_q <= step_edge;
                state_q     <= StReq;
              end
            end
          end
          StReq: begin
            mem_rd_q <= 1'b0;
            tmo_q    <= '0;
            state_q  <= StWait;
          end
          StWait: begin
            if (mem_ack_i) begin
              if (squash_q) begin
                squash_q <= 1'b0;
                state_q  <= StIdle;
              end else begin
                instr_q       <= mem_rdata_i;
                instr_pc_q    <= pc_q;
                pc_q          <= pc_q + PcInc;
                instr_valid_q <= 1'b1;
                state_q       <= StHold;
              end
            end else if (tmo_hit) begin
              squash_q <= 1'b0;
              fault_q  <= 1'b1;
              state_q  <= StFault;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          StHold: begin
            if (instr_ready_i) begin
              instr_valid_q <= 1'b0;
              state_q       <= StIdle;
            end
          end
          StHalt: begin
            // skip lets the breakpointed instruction be fetched exactly once after resume.
            if (resume_i) begin
              halted_q <= 1'b0;
              skip_q   <= 1'b1;
              state_q  <= StIdle;
            end
          end
          StFault: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign mem_addr_o    = mem_addr_q;
  assign mem_rd_o      = mem_rd_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = instr_valid_q;
  assign pc_o          = pc_q;
  assign halted_o      = halted_q;
  assign fault_o       = fault_q;

endmodule
